// File: rtl/iterative_shifter.sv
// Multi-cycle 8-bit shifter: one bit per clock through IDLE -> SHIFT -> FIN.
// Define SHIFTER_ROTATE_EN to add rotate support for CTRL type 2'b10.
module iterative_shifter (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       START,
  input  logic [7:0] DATA,
  input  logic [7:0] CTRL,
  input  logic       DIR,
  output logic [7:0] RESULT,
  output logic       BUSY,
  output logic       DONE
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StFin   = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] work_q, work_d;
  logic [7:0] result_q, result_d;
  logic [7:0] step_val;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] cnt_load;
  logic       dir_q, dir_d;
  logic       arith_q, arith_d;
  logic       unused_ctrl;

`ifdef SHIFTER_ROTATE_EN
  logic rot_q, rot_d;
  logic rot_sel;

  assign rot_sel = (CTRL[7:6] == 2'b10);
`endif

  assign unused_ctrl = ^CTRL[5:4];

  // Logical/arithmetic counts saturate at 8; rotate counts wrap modulo 8.
  always_comb begin
    cnt_load = (CTRL[3:0] > 4'd8) ? 4'd8 : CTRL[3:0];
`ifdef SHIFTER_ROTATE_EN
    if (rot_sel) begin
      cnt_load = {1'b0, CTRL[2:0]};
    end
`endif
  end

  // Single-bit step; arithmetic only matters on right shifts.
  always_comb begin
    if (!dir_q) begin
      step_val = {work_q[6:0], 1'b0};
`ifdef SHIFTER_ROTATE_EN
      if (rot_q) begin
        step_val[0] = work_q[7];
      end
`endif
    end else begin
      step_val = {arith_q & work_q[7], work_q[7:1]};
`ifdef SHIFTER_ROTATE_EN
      if (rot_q) begin
        step_val[7] = work_q[0];
      end
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    arith_d  = arith_q;
    result_d = result_q;
`ifdef SHIFTER_ROTATE_EN
    rot_d    = rot_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (START) begin
          work_d  = DATA;
          cnt_d   = cnt_load;
          dir_d   = DIR;
          arith_d = (CTRL[7:6] == 2'b01);
`ifdef SHIFTER_ROTATE_EN
          rot_d   = rot_sel;
`endif
          if (cnt_load == 4'd0) begin
            state_d  = StFin;
            result_d = DATA;
          end else begin
            state_d = StShift;
          end
        end
      end
      StShift: begin
        work_d = step_val;
        cnt_d  = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d  = StFin;
          result_d = step_val;
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= StIdle;
      work_q   <= 8'h00;
      cnt_q    <= 4'd0;
      dir_q    <= 1'b0;
      arith_q  <= 1'b0;
      result_q <= 8'h00;
`ifdef SHIFTER_ROTATE_EN
      rot_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
      arith_q  <= arith_d;
      result_q <= result_d;
`ifdef SHIFTER_ROTATE_EN
      rot_q    <= rot_d;
`endif
    end
  end

  assign RESULT = result_q;
  assign BUSY   = (state_q == StShift);
  assign DONE   = (state_q == StFin);

endmodule

// File: tb/tb_iterative_shifter.sv
// Scoreboard bench for iterative_shifter; expected results are queued at capture time
// and popped when DONE is observed.
module tb_iterative_shifter;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       START;
  logic [7:0] DATA;
  logic [7:0] CTRL;
  logic       DIR;
  logic [7:0] RESULT;
  logic       BUSY;
  logic       DONE;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic [7:0] res;
    int         n;
  } exp_t;

  exp_t sb[$];

  iterative_shifter dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .START  (START),
    .DATA   (DATA),
    .CTRL   (CTRL),
    .DIR    (DIR),
    .RESULT (RESULT),
    .BUSY   (BUSY),
    .DONE   (DONE)
  );

  always #5 CLK = ~CLK;

  function automatic exp_t model(input logic [7:0] d, input logic [7:0] c, input logic r);
    exp_t        e;
    logic [15:0] dd;
    logic        rot;
    int          n;
`ifdef SHIFTER_ROTATE_EN
    rot = (c[7:6] == 2'b10);
`else
    rot = 1'b0;
`endif
    if (rot) begin
      n  = int'(c[2:0]);
      dd = {d, d};
      if (!r) begin
        dd    = dd << n;
        e.res = dd[15:8];
      end else begin
        dd    = dd >> n;
        e.res = dd[7:0];
      end
    end else begin
      n = int'(c[3:0]);
      if (n > 8) n = 8;
      if (!r) e.res = d << n;
      else if (c[7:6] == 2'b01) e.res = 8'($signed(d) >>> n);
      else e.res = d >> n;
    end
    e.n = n;
    return e;
  endfunction

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s: got %02h, expected %02h", name, act, req);
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    START = 1'b0;
    DATA  = 8'h00;
    CTRL  = 8'h00;
    DIR   = 1'b0;
    repeat (2) @(negedge CLK);
    tests_run++;
    if (RESULT !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_result: got %02h, expected 00", RESULT);
    end
    tests_run++;
    if (BUSY !== 1'b0 || DONE !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: busy=%b done=%b, expected 0 0", BUSY, DONE);
    end
    RESET = 1'b0;
    @(negedge CLK);
  endtask

  // has_ref: also compare against a literal value from the requirement vectors.
  task automatic run_op(input string name, input logic [7:0] d, input logic [7:0] c,
                        input logic r, input bit has_ref, input logic [7:0] ref_res);
    exp_t       e;
    logic [7:0] res;
    int         busy;
    int         cyc;
    bit         got;
    sb.push_back(model(d, c, r));
    @(negedge CLK);
    DATA  = d;
    CTRL  = c;
    DIR   = r;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    DATA  = ~d;
    CTRL  = 8'($urandom);
    DIR   = ~r;
    busy  = 0;
    cyc   = 0;
    got   = 1'b0;
    res   = 8'h00;
    while (!got && cyc < 20) begin
      if (DONE === 1'b1) begin
        got = 1'b1;
        res = RESULT;
      end else begin
        if (BUSY === 1'b1) busy++;
        @(negedge CLK);
        cyc++;
      end
    end
    e = sb.pop_front();
    tests_run++;
    if (!got) begin
      tests_failed++;
      $display("FAIL %s_done: no DONE within 20 cycles, expected DONE after %0d", name, e.n);
      return;
    end
    tests_run++;
    if (res !== e.res) begin
      tests_failed++;
      $display("FAIL %s_result: got %02h, expected %02h", name, res, e.res);
    end
    tests_run++;
    if (busy != e.n) begin
      tests_failed++;
      $display("FAIL %s_busy: got %0d busy cycles, expected %0d", name, busy, e.n);
    end
    if (has_ref) check8({name, "_ref"}, res, ref_res);
    @(negedge CLK);
    tests_run++;
    if (DONE !== 1'b0 || BUSY !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_fin_len: done=%b busy=%b, expected 0 0", name, DONE, BUSY);
    end
  endtask

  task automatic test_vectors();
    run_op("left3", 8'h81, 8'h03, 1'b0, 1'b1, 8'h08);
    run_op("arith_r2", 8'h90, 8'h42, 1'b1, 1'b1, 8'hE4);
    run_op("logic_r2", 8'h90, 8'h02, 1'b1, 1'b1, 8'h24);
    run_op("arith_l2", 8'h90, 8'h42, 1'b0, 1'b1, 8'h40);
    run_op("type11_r2", 8'h90, 8'hC2, 1'b1, 1'b1, 8'h24);
`ifdef SHIFTER_ROTATE_EN
    run_op("rot_l1", 8'h81, 8'h81, 1'b0, 1'b1, 8'h03);
    run_op("rot_r1", 8'h81, 8'h81, 1'b1, 1'b1, 8'hC0);
    run_op("rot_8", 8'h81, 8'h88, 1'b0, 1'b1, 8'h81);
`else
    run_op("rot_l1", 8'h81, 8'h81, 1'b0, 1'b1, 8'h02);
    run_op("rot_r1", 8'h81, 8'h81, 1'b1, 1'b1, 8'h40);
    run_op("rot_8", 8'h81, 8'h88, 1'b0, 1'b1, 8'h00);
`endif
  endtask

  task automatic test_boundary();
    run_op("sat_r15", 8'hFF, 8'h0F, 1'b1, 1'b1, 8'h00);
    run_op("arith_r8", 8'h80, 8'h48, 1'b1, 1'b1, 8'hFF);
    run_op("zero_cnt", 8'h5A, 8'h00, 1'b0, 1'b1, 8'h5A);
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++) begin
      run_op("rand", 8'($urandom), 8'($urandom), 1'($urandom), 1'b0, 8'h00);
    end
  endtask

  task automatic test_restart();
    exp_t       e;
    int         dones;
    int         busy;
    logic [7:0] res;
    sb.push_back(model(8'h0F, 8'h05, 1'b0));
    @(negedge CLK);
    DATA  = 8'h0F;
    CTRL  = 8'h05;
    DIR   = 1'b0;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    dones = 0;
    busy  = 0;
    res   = 8'h00;
    for (int k = 1; k <= 15; k++) begin
      if (DONE === 1'b1) begin
        dones++;
        res = RESULT;
      end
      if (BUSY === 1'b1) busy++;
      START = (k == 2);
      if (k == 2) begin
        DATA = 8'hFF;
        CTRL = 8'h01;
        DIR  = 1'b1;
      end
      @(negedge CLK);
    end
    e = sb.pop_front();
    tests_run++;
    if (dones != 1) begin
      tests_failed++;
      $display("FAIL restart_dones: got %0d DONE pulses, expected 1", dones);
    end
    tests_run++;
    if (busy != e.n) begin
      tests_failed++;
      $display("FAIL restart_busy: got %0d busy cycles, expected %0d", busy, e.n);
    end
    check8("restart_result", res, e.res);
  endtask

  task automatic test_abort();
    int dones;
    int busy;
    @(negedge CLK);
    DATA  = 8'h33;
    CTRL  = 8'h05;
    DIR   = 1'b0;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    check8("abort_result", RESULT, 8'h00);
    dones = 0;
    busy  = 0;
    for (int k = 0; k < 10; k++) begin
      if (DONE === 1'b1) dones++;
      if (BUSY === 1'b1) busy++;
      @(negedge CLK);
    end
    tests_run++;
    if (dones != 0 || busy != 0) begin
      tests_failed++;
      $display("FAIL abort_idle: got %0d DONE and %0d busy cycles, expected 0 0", dones, busy);
    end
  endtask

  task automatic test_start_reset();
    int dones;
    int busy;
    run_op("pre_sr", 8'hC3, 8'h01, 1'b1, 1'b1, 8'h61);
    @(negedge CLK);
    DATA  = 8'hAA;
    CTRL  = 8'h03;
    DIR   = 1'b0;
    START = 1'b1;
    RESET = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    RESET = 1'b0;
    check8("sr_result", RESULT, 8'h00);
    dones = 0;
    busy  = 0;
    for (int k = 0; k < 8; k++) begin
      if (DONE === 1'b1) dones++;
      if (BUSY === 1'b1) busy++;
      @(negedge CLK);
    end
    tests_run++;
    if (dones != 0 || busy != 0) begin
      tests_failed++;
      $display("FAIL sr_idle: got %0d DONE and %0d busy cycles, expected 0 0", dones, busy);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_boundary();
    test_random();
    test_restart();
    test_abort();
    test_start_reset();
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_empty: got %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/iterative_shifter.md
ITERATIVE_SHIFTER -- requirements
Module: iterative_shifter

Interface
REQ-001: Ports SHALL be: CLK  input  1  single system clock; all state updates on rising edge.
REQ-002: RESET  input  1  synchronous, active-high reset, sampled on CLK rising edge.
REQ-003: START  input  1  request; sampled only in IDLE.
REQ-004: DATA  input  8  operand to shift.
REQ-005: CTRL  input  8  [7:6] type (00 logical, 01 arithmetic, 10 rotate, 11 treated as 00); [3:0] count; [5:4] ignored.
REQ-006: DIR  input  1  0 = left, 1 = right.
REQ-007: RESULT  output  8  last completed result, held between operations.
REQ-008: BUSY  output  1  high while state is SHIFT.
REQ-009: DONE  output  1  one-cycle completion pulse.
REQ-010: No parameters; one clock, reset synchronous active-high.

Function
REQ-011: FSM states SHALL be IDLE, SHIFT and FIN; BUSY = (state == SHIFT); DONE = (state == FIN).
REQ-012: In IDLE with START = 1: latch DATA, CTRL, DIR; load remaining count n; next state SHIFT if n > 0, else FIN.
REQ-013: Count n for logical/arithmetic: CTRL[3:0], saturated to 8 when greater than 8.
REQ-014: Count n for rotate: CTRL[2:0] (count modulo 8; count 8 gives n = 0).
REQ-015: In SHIFT, each edge: shift working register by exactly one bit; decrement n; on n == 1 go to FIN.
REQ-016: Shift rules per step:
  - left (any type except rotate): insert 0 at bit 0;
  - right logical: insert 0 at bit 7;
  - right arithmetic: replicate bit 7;
  - rotate left: bit 7 to bit 0;
  - rotate right: bit 0 to bit 7.
REQ-017: Arithmetic left SHALL equal logical left.
REQ-018: RESULT SHALL load the working register on the edge entering FIN, and hold otherwise.
REQ-019: Latency: DONE SHALL be high in the cycle after capture edge + n edges; n = 0 gives DONE in the cycle right after capture, with RESULT = DATA.
REQ-020: FIN SHALL last exactly one cycle, then IDLE.
REQ-021: START in SHIFT or FIN SHALL be ignored and not queued.
REQ-022: DATA, CTRL and DIR changes after capture SHALL NOT affect the operation in flight.

Reset
REQ-023: RESET SHALL force IDLE, RESULT = 0x00, BUSY = 0, DONE = 0 and clear the working register and count on the sampling edge.
REQ-024: RESET mid-operation SHALL abandon the operation with no DONE pulse; RESULT = 0x00.
REQ-025: RESET SHALL take priority over START on the same edge.

Configuration
REQ-026: Macro SHIFTER_ROTATE_EN defined: rotate (CTRL[7:6] = 10) SHALL behave per REQ-014/REQ-016.
REQ-027: Macro SHIFTER_ROTATE_EN undefined: type 10 SHALL be treated as logical (REQ-013 count, zero fill), and no rotate logic SHALL be synthesized.

Verification
REQ-028: DATA = 0x81, CTRL = 0x03, DIR = 0, START -> BUSY for 3 cycles, DONE pulse in the 4th cycle after capture, RESULT = 0x08.
REQ-029: DATA = 0x90, CTRL = 0x42, DIR = 1 -> RESULT = 0xE4 after 2 shift cycles; same with CTRL = 0x02 -> 0x24.
REQ-030: Rotate, DATA = 0x81, CTRL = 0x81:
  - with SHIFTER_ROTATE_EN: DIR = 0 -> 0x03; DIR = 1 -> 0xC0;
  - without SHIFTER_ROTATE_EN: DIR = 0 -> 0x02; DIR = 1 -> 0x40.
REQ-031: Boundary counts:
  - DATA = 0xFF, CTRL = 0x0F, DIR = 1 -> 8 BUSY cycles, RESULT = 0x00;
  - DATA = 0x80, CTRL = 0x48, DIR = 1 -> 0xFF;
  - DATA = 0x5A, CTRL = 0x00 -> no BUSY, DONE next cycle, RESULT = 0x5A.
REQ-032: Abort and re-trigger:
  - START with CTRL = 0x05, re-assert START at cycle 2 -> ignored, single DONE;
  - RESET at cycle 3 -> no DONE, RESULT = 0x00, IDLE;
  - START + RESET on the same edge -> stays IDLE.
